// File: rtl/multicore_run_ctrl.sv
// multicore_run_ctrl: launches masked cores on one start request, gathers sticky done flags, ends on completion or timeout.
// Define STAGGER_START_EN to launch selected cores one per cycle instead of all together.
module multicore_run_ctrl #(
  parameter int CORE_COUNT = 3,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  startN,
  input  logic [CORE_COUNT-1:0] core_en_mask,
  input  logic [CORE_COUNT-1:0] core_ready,
  input  logic [CORE_COUNT-1:0] core_done,
  input  logic [CNT_W-1:0]      timeout_limit,
  output logic [CORE_COUNT-1:0] core_startN,
  output logic                  processor_ready,
  output logic                  processDone,
  output logic                  timeout_err,
  output logic [CORE_COUNT-1:0] done_mask,
  output logic [CNT_W-1:0]      cycle_count
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, RUN = 2'd2, FINISH = 2'd3;
  logic [1:0] state_q, state_d;
  logic [CORE_COUNT-1:0] core_startN_q, core_startN_d, done_mask_q, done_mask_d, active_q, active_d, hit;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d, lim_q, lim_d, cnt_inc;
  logic ready_q, ready_d, done_q, done_d, terr_q, terr_d, armed_q, armed_d, complete, timeout;
`ifdef STAGGER_START_EN
  localparam int SW = $clog2(CORE_COUNT + 1);
  logic [SW-1:0] slot_q, slot_d;
  logic [CORE_COUNT-1:0] launched;
  // cores whose start slot has already passed may report done during START
  always_comb begin
    launched = '0;
    for (int i = 0; i < CORE_COUNT; i++) launched[i] = SW'(i) < slot_q;
  end
`endif
  assign hit = done_mask_q | (core_done & active_q);
  assign complete = hit == active_q;
  assign timeout = (lim_q != '0) && (({1'b0, cycle_count_q} + 1'b1) == {1'b0, lim_q});
  assign cnt_inc = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;
  // next-state and output computation for the run sequence
  always_comb begin
    state_d = state_q;
    core_startN_d = '1;
    ready_d = 1'b0;
    done_d = done_q;
    terr_d = terr_q;
    done_mask_d = done_mask_q;
    cycle_count_d = cycle_count_q;
    active_d = active_q;
    lim_d = lim_q;
    armed_d = startN ? 1'b1 : armed_q;
`ifdef STAGGER_START_EN
    slot_d = slot_q;
`endif
    case (state_q)
      IDLE: begin
        ready_d = (&(core_ready | ~core_en_mask)) && (|core_en_mask);
        if (!startN && ready_q && armed_q) begin
          active_d = core_en_mask;
          lim_d = timeout_limit;
          done_mask_d = '0;
          cycle_count_d = '0;
          done_d = 1'b0;
          terr_d = 1'b0;
          armed_d = 1'b0;
          ready_d = 1'b0;
          state_d = START;
`ifdef STAGGER_START_EN
          slot_d = '0;
          core_startN_d = ~(core_en_mask & CORE_COUNT'(1));
`else
          core_startN_d = ~core_en_mask;
`endif
        end
      end
      START: begin
`ifdef STAGGER_START_EN
        done_mask_d = done_mask_q | (core_done & active_q & launched);
        cycle_count_d = cnt_inc;
        if (slot_q == SW'(CORE_COUNT - 1)) state_d = RUN;
        else begin
          slot_d = slot_q + 1'b1;
          core_startN_d = ~(active_q & (CORE_COUNT'(1) << (slot_q + 1'b1)));
        end
`else
        state_d = RUN;
`endif
      end
      RUN: begin
        done_mask_d = hit;
        cycle_count_d = cnt_inc;
        state_d = (complete || timeout) ? FINISH : RUN;
        terr_d = !complete && timeout;
      end
      default: begin
        done_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  // registered state with synchronous active-low reset that aborts any run
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= IDLE;
      core_startN_q <= '1;
      ready_q <= 1'b0;
      done_q <= 1'b0;
      terr_q <= 1'b0;
      done_mask_q <= '0;
      cycle_count_q <= '0;
      active_q <= '0;
      lim_q <= '0;
      armed_q <= 1'b1;
`ifdef STAGGER_START_EN
      slot_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      core_startN_q <= core_startN_d;
      ready_q <= ready_d;
      done_q <= done_d;
      terr_q <= terr_d;
      done_mask_q <= done_mask_d;
      cycle_count_q <= cycle_count_d;
      active_q <= active_d;
      lim_q <= lim_d;
      armed_q <= armed_d;
`ifdef STAGGER_START_EN
      slot_q <= slot_d;
`endif
    end
  end
  assign core_startN = core_startN_q;
  assign processor_ready = ready_q;
  assign processDone = done_q;
  assign timeout_err = terr_q;
  assign done_mask = done_mask_q;
  assign cycle_count = cycle_count_q;
endmodule

// File: tb/tb_multicore_run_ctrl.sv
// tb_multicore_run_ctrl: scoreboard bench for the multi-core run controller.
module tb_multicore_run_ctrl;
  logic clk = 1'b0;
  logic rstN, startN;
  logic [2:0] core_en_mask, core_ready, core_done, core_startN, done_mask;
  logic [15:0] timeout_limit, cycle_count;
  logic processor_ready, processDone, timeout_err;
  int n_cmp = 0, n_bad = 0;
`ifdef STAGGER_START_EN
  localparam int OFF = 3;
`else
  localparam int OFF = 0;
`endif
  typedef struct packed {
    logic [2:0] dm;
    logic [15:0] cnt;
    logic te;
  } exp_t;
  exp_t sb[$];

  multicore_run_ctrl #(.CORE_COUNT(3), .CNT_W(16)) dut (
    .clk(clk), .rstN(rstN), .startN(startN), .core_en_mask(core_en_mask),
    .core_ready(core_ready), .core_done(core_done), .timeout_limit(timeout_limit),
    .core_startN(core_startN), .processor_ready(processor_ready), .processDone(processDone),
    .timeout_err(timeout_err), .done_mask(done_mask), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [2:0] m, input logic [15:0] lim, input int d0, input int d1, input int d2,
                     input bit lvl, input bit hold);
    int d[3];
    int c, e;
    bit te, seen;
    exp_t x, y;
    logic [2:0] dmx, prog;
    d[0] = d0; d[1] = d1; d[2] = d2;
    c = 0;
    for (int i = 0; i < 3; i++) if (m[i]) c = (d[i] == 0) ? 1000 : (d[i] > c ? d[i] : c);
    te = (lim != 0) && (int'(lim) - OFF < c);
    e = te ? int'(lim) - OFF : c;
    for (int i = 0; i < 3; i++) dmx[i] = m[i] && d[i] != 0 && d[i] <= e;
    x.dm = dmx; x.cnt = 16'(OFF + e); x.te = te;
    core_en_mask = m; timeout_limit = lim; core_done = '0; startN = 1'b1;
    repeat (2) @(negedge clk);
    startN = 1'b0;
    sb.push_back(x);
    @(negedge clk);
`ifdef STAGGER_START_EN
    for (int k = 0; k < 3; k++) begin
      chk("start_slot", {29'd0, core_startN}, {29'd0, ~(m & (3'b001 << k))});
      if (!hold) startN = 1'b1;
      @(negedge clk);
    end
`else
    chk("start_pulse", {29'd0, core_startN}, {29'd0, ~m});
    if (!hold) startN = 1'b1;
    @(negedge clk);
`endif
    chk("start_once", {29'd0, core_startN}, 32'h7);
    seen = 1'b0;
    for (int j = 1; j <= 300 && !seen; j++) begin
      if (processDone) begin
        seen = 1'b1;
        if (sb.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
        else begin
          y = sb.pop_front();
          chk("done_mask", {29'd0, done_mask}, {29'd0, y.dm});
          chk("cycle_count", {16'd0, cycle_count}, {16'd0, y.cnt});
          chk("timeout_err", {31'd0, timeout_err}, {31'd0, y.te});
        end
      end else begin
        if (j <= e) begin
          for (int i = 0; i < 3; i++) prog[i] = m[i] && d[i] != 0 && d[i] < j;
          chk("dm_progress", {29'd0, done_mask}, {29'd0, prog});
          chk("cnt_progress", {16'd0, cycle_count}, 32'(OFF + j - 1));
        end
        for (int i = 0; i < 3; i++) core_done[i] = lvl ? (d[i] != 0 && j >= d[i]) : (d[i] == j);
        @(negedge clk);
      end
    end
    if (!seen) chk("done_wait", 32'd0, 32'd1);
    core_done = '0;
  endtask

  initial begin
    rstN = 1'b0; startN = 1'b1; core_en_mask = 3'b111; core_ready = 3'b111;
    core_done = 3'b111; timeout_limit = '0;
    repeat (2) @(negedge clk);
    chk("rst_startN", {29'd0, core_startN}, 32'h7);
    chk("rst_ready", {31'd0, processor_ready}, 32'd0);
    chk("rst_done", {31'd0, processDone}, 32'd0);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);
    chk("rst_dm", {29'd0, done_mask}, 32'd0);
    chk("rst_cnt", {16'd0, cycle_count}, 32'd0);
    rstN = 1'b1; core_done = '0;
    repeat (2) @(negedge clk);
    chk("ready_idle", {31'd0, processor_ready}, 32'd1);
    run(3'b111, 16'd0, 4, 7, 10, 1'b0, 1'b0);
    run(3'b101, 16'd0, 3, 2, 6, 1'b0, 1'b0);
    run(3'b111, 16'd5, 2, 3, 0, 1'b0, 1'b0);
    run(3'b111, 16'd6, 2, 3, 6, 1'b0, 1'b0);
    run(3'b011, 16'd0, 2, 5, 1, 1'b1, 1'b0);
    run(3'b111, 16'd0, 1, 2, 3, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      chk("held_no_restart", {29'd0, core_startN}, 32'h7);
      chk("held_done_sticky", {31'd0, processDone}, 32'd1);
      @(negedge clk);
    end
    run(3'b110, 16'd0, 0, 2, 3, 1'b0, 1'b0);
    core_ready = 3'b011; core_en_mask = 3'b111; startN = 1'b1;
    repeat (2) @(negedge clk);
    chk("not_ready", {31'd0, processor_ready}, 32'd0);
    startN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ignored_start", {29'd0, core_startN}, 32'h7);
      chk("ignored_done", {31'd0, processDone}, 32'd1);
    end
    startN = 1'b1; core_ready = 3'b111;
    repeat (2) @(negedge clk);
    startN = 1'b0;
    repeat (2) @(negedge clk);
    startN = 1'b1;
    repeat (5) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    chk("abort_startN", {29'd0, core_startN}, 32'h7);
    chk("abort_done", {31'd0, processDone}, 32'd0);
    chk("abort_dm", {29'd0, done_mask}, 32'd0);
    chk("abort_cnt", {16'd0, cycle_count}, 32'd0);
    chk("abort_ready", {31'd0, processor_ready}, 32'd0);
    rstN = 1'b1;
    run(3'b001, 16'd3, 0, 0, 0, 1'b0, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
